jump_target_unit: RTL

Parametrised control-flow target generator for the multicycle MIPS datapath. It computes pseudo-direct jump (J/JAL), PC-relative branch (BEQ/BNE) and register-jump (JR) targets through a small FSM with a registered result and a start/valid handshake. It also keeps a return-address stack (RAS) that cross-checks JR $ra targets. It sits between the instruction register and the PC-source mux, and the control unit starts it during the decode state.

---
 rtl/jump_target_unit.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/jump_target_unit.sv
// Jump/branch/JR target generator with a registered result, a
// start/valid handshake and a return-address stack for JR $ra checks.
module jump_target_unit #(
  parameter int WIDTH     = 32,
  parameter int REGW      = 5,
  parameter int IMMW      = 16,
  parameter int SHIFT     = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [1:0]                     mode,
  input  logic [WIDTH-1:0]               pc_in,
  input  logic [REGW-1:0]                rs,
  input  logic [REGW-1:0]                rt,
  input  logic [IMMW-1:0]                imm,
  input  logic [WIDTH-1:0]               rs_value,
  input  logic                           flush,
  output logic [WIDTH-1:0]               target_out,
  output logic                           target_valid,
  output logic                           busy,
  output logic                           misaligned,
  output logic                           ras_empty,
  output logic                           ras_mismatch,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count
);

  localparam int FW = 2*REGW + IMMW;
  localparam int CW = $clog2(RAS_DEPTH+1);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] HI_MASK = {WIDTH{1'b1}} << (FW + SHIFT);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_CALC = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic [1:0] M_J   = 2'b00;
  localparam logic [1:0] M_BR  = 2'b01;
  localparam logic [1:0] M_JR  = 2'b10;
  localparam logic [1:0] M_JAL = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [REGW-1:0]  rs_q, rs_d;
  logic [REGW-1:0]  rt_q, rt_d;
  logic [IMMW-1:0]  imm_q, imm_d;
  logic [WIDTH-1:0] rsv_q, rsv_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             mis_q, mis_d;
  logic             empty_q, empty_d;
  logic             mm_q, mm_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic             ras_we;
  logic [CW-1:0]    cnt_base;
  logic [PW-1:0]    ptr_inc, ptr_dec;
  logic [WIDTH-1:0] j_tgt, br_tgt;
  logic             is_ra;

  assign j_tgt  = (pc_q & HI_MASK) | (WIDTH'({rs_q, rt_q, imm_q}) << SHIFT);
  assign br_tgt = pc_q + ({{(WIDTH-IMMW){imm_q[IMMW-1]}}, imm_q} << SHIFT);
  assign is_ra  = (rs_q == {REGW{1'b1}});

  assign ptr_inc = (ptr_q == PW'(RAS_DEPTH-1)) ? '0 : ptr_q + PW'(1);
  assign ptr_dec = (ptr_q == '0) ? PW'(RAS_DEPTH-1) : ptr_q - PW'(1);

  // flush clears occupancy before any same-cycle push or pop
  assign cnt_base = flush ? '0 : cnt_q;

  // FSM, target selection and return-address stack bookkeeping
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    pc_d     = pc_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    imm_d    = imm_q;
    rsv_d    = rsv_q;
    target_d = target_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    mis_d    = mis_q;
    empty_d  = empty_q;
    mm_d     = mm_q;
    cnt_d    = cnt_base;
    ptr_d    = ptr_q;
    ras_we   = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        busy_d  = 1'b0;
        mis_d   = 1'b0;
        empty_d = 1'b0;
        mm_d    = 1'b0;
        if (start) begin
          mode_d  = mode;
          pc_d    = pc_in;
          rs_d    = rs;
          rt_d    = rt;
          imm_d   = imm;
          rsv_d   = rs_value;
          busy_d  = 1'b1;
          state_d = S_CALC;
        end
      end
      (state_q == S_CALC): begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        state_d = S_DONE;
        unique case (1'b1)
          (mode_q == M_J): target_d = j_tgt;
          (mode_q == M_BR): target_d = br_tgt;
          (mode_q == M_JAL): begin
            target_d = j_tgt;
            ras_we   = 1'b1;
            ptr_d    = ptr_inc;
            if (cnt_base != CW'(RAS_DEPTH))
              cnt_d = cnt_base + CW'(1);
          end
          (mode_q == M_JR): begin
            target_d = rsv_q;
            mis_d    = |rsv_q[SHIFT-1:0];
            if (is_ra) begin
              if (cnt_base == '0) begin
                empty_d = 1'b1;
              end else begin
                ptr_d = ptr_dec;
                cnt_d = cnt_base - CW'(1);
                mm_d  = (ras_mem[ptr_dec] != rsv_q);
              end
            end
          end
          default: ;
        endcase
      end
      (state_q == S_DONE): begin
        busy_d  = 1'b0;
        mis_d   = 1'b0;
        empty_d = 1'b0;
        mm_d    = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mode_q   <= '0;
      pc_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      imm_q    <= '0;
      rsv_q    <= '0;
      target_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      mis_q    <= 1'b0;
      empty_q  <= 1'b0;
      mm_q     <= 1'b0;
      cnt_q    <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      pc_q     <= pc_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      imm_q    <= imm_d;
      rsv_q    <= rsv_d;
      target_q <= target_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      mis_q    <= mis_d;
      empty_q  <= empty_d;
      mm_q     <= mm_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
    end
  end

  // stack storage; contents need no reset since occupancy gates reads
  always_ff @(posedge clk) begin
    if (ras_we)
      ras_mem[ptr_q] <= pc_q;
  end

  assign target_out   = target_q;
  assign target_valid = valid_q;
  assign busy         = busy_q;
  assign misaligned   = mis_q;
  assign ras_empty    = empty_q;
  assign ras_mismatch = mm_q;
  assign ras_count    = cnt_q;

endmodule
